// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator between the execute stage and a word-wide data memory. Takes one
//   load/store at a time, presents a word address to the memory, returns
//   sign/zero-extended load data, and performs sub-word stores as
//   read-modify-write so the memory only ever sees full-word writes.
//
//   Optional build macro: LSU_FAULT_EN
//     defined   : misaligned H/W, size 11, or store with FUNCT3[2]=1 fault;
//                 no memory access, DONE+ERR one cycle after accept.
//     undefined : ERR tied 0, size 11 acts as W, misaligned H uses the
//                 ADDR[1] half, misaligned W ignores ADDR[1:0].
//
// Ports
//   CLK, RST_N        clock (rising edge), asynchronous active-low reset
//   REQ, WE, FUNCT3,  request strobe / store select / size+unsigned /
//   ADDR, WDATA       byte address / store data (sampled when READY=1)
//   READY, DONE, ERR  idle flag, one-cycle completion pulse, fault flag
//   RDATA             registered load result
//   MEM_A, MEM_WD,    memory word address, write data, write enable
//   MEM_WE, MEM_RD    and combinational read data
module load_store_unit #(
  parameter int AW = 6
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          REQ,
  input  logic          WE,
  input  logic [2:0]    FUNCT3,
  input  logic [31:0]   ADDR,
  input  logic [31:0]   WDATA,
  output logic          READY,
  output logic          DONE,
  output logic [31:0]   RDATA,
  output logic          ERR,
  output logic [AW-1:0] MEM_A,
  output logic [31:0]   MEM_WD,
  output logic          MEM_WE,
  input  logic [31:0]   MEM_RD
);

  typedef enum logic [2:0] {IDLE, LOAD, READ, WRITE, FIN} state_t;

  state_t      state, state_nxt;
  logic [1:0]  size_q;      // 00 B, 01 H, 1x W
  logic        uns_q;
  logic [1:0]  off_q;       // byte offset within the word
  logic [31:0] wdata_q;
  logic        fault_q;
  logic        fault_in;
  logic        accept;

  assign accept = (state == IDLE) && REQ;

  // Fault classification of the request currently on the inputs.
`ifdef LSU_FAULT_EN
  always_comb begin
    fault_in = 1'b0;
    if (FUNCT3[1:0] == 2'b11)                          fault_in = 1'b1;
    if (FUNCT3[1:0] == 2'b01 && ADDR[0])               fault_in = 1'b1;
    if (FUNCT3[1:0] == 2'b10 && ADDR[1:0] != 2'b00)    fault_in = 1'b1;
    if (WE && FUNCT3[2])                               fault_in = 1'b1;
  end
`else
  assign fault_in = 1'b0;
`endif

  // Pick the addressed lane out of a memory word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] w,
                                               input logic [1:0]  size,
                                               input logic        uns,
                                               input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (size)
      2'b00:   load_extract = {{24{~uns & b[7]}}, b};
      2'b01:   load_extract = {{16{~uns & h[15]}}, h};
      default: load_extract = w;
    endcase
  endfunction

  // Replace the addressed lane(s) of the old word with the store data.
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off);
    logic [31:0] r;
    r = old;
    case (size)
      2'b00:   r[{off, 3'b000} +: 8]     = wd[7:0];
      2'b01:   r[{off[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // Next-state logic; outputs below are pure decodes of the state.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE: if (REQ) begin
        if (fault_in)       state_nxt = FIN;
        else if (!WE)       state_nxt = LOAD;
        else if (FUNCT3[1]) state_nxt = WRITE;   // SW (size 11 too when faults off)
        else                state_nxt = READ;    // SB/SH need the old word first
      end
      LOAD:    state_nxt = FIN;
      READ:    state_nxt = WRITE;
      WRITE:   state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoding from state means an asynchronous reset drops MEM_WE at once.
  assign READY  = (state == IDLE);
  assign DONE   = (state == FIN);
  assign MEM_WE = (state == WRITE);
`ifdef LSU_FAULT_EN
  assign ERR    = DONE && fault_q;
`else
  assign ERR    = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state   <= IDLE;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      wdata_q <= '0;
      fault_q <= 1'b0;
      RDATA   <= '0;
      MEM_A   <= '0;
      MEM_WD  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          size_q  <= FUNCT3[1:0];
          uns_q   <= FUNCT3[2];
          off_q   <= ADDR[1:0];
          wdata_q <= WDATA;
          fault_q <= fault_in;
          if (!fault_in) begin
            MEM_A <= ADDR[AW+1:2];               // upper address bits wrap
            if (WE && FUNCT3[1]) MEM_WD <= WDATA;
          end
        end
        LOAD:  RDATA  <= load_extract(MEM_RD, size_q, uns_q, off_q);
        READ:  MEM_WD <= store_merge(MEM_RD, wdata_q, size_q, off_q);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// loads/stores compared against a byte-array memory model.
module tb_load_store_unit;
  localparam int AW = 6;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          REQ = 1'b0;
  logic          WE = 1'b0;
  logic [2:0]    FUNCT3 = 3'b000;
  logic [31:0]   ADDR = '0;
  logic [31:0]   WDATA = '0;
  logic          READY, DONE, ERR, MEM_WE;
  logic [31:0]   RDATA, MEM_WD, MEM_RD;
  logic [AW-1:0] MEM_A;

  load_store_unit #(.AW(AW)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .WE(WE), .FUNCT3(FUNCT3),
    .ADDR(ADDR), .WDATA(WDATA), .READY(READY), .DONE(DONE), .RDATA(RDATA),
    .ERR(ERR), .MEM_A(MEM_A), .MEM_WD(MEM_WD), .MEM_WE(MEM_WE), .MEM_RD(MEM_RD)
  );

  always #5 CLK = ~CLK;

  // Environment memory driven by the DUT.
  logic [31:0] mem [2**AW] = '{default: 32'h0};
  assign MEM_RD = mem[MEM_A];
  always @(posedge CLK) if (MEM_WE) mem[MEM_A] <= MEM_WD;

  // Reference model: byte-addressed memory plus last load result.
  logic [7:0]  ref_bytes [4*(2**AW)] = '{default: 8'h0};
  logic [31:0] ref_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return f3[1] ? 4 : (f3[0] ? 2 : 1);
  endfunction

  function automatic bit ref_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_FAULT_EN
    return (f3[1:0] == 2'b11) || (f3[1:0] == 2'b01 && a[0]) ||
           (f3[1:0] == 2'b10 && a[1:0] != 2'b00) || (we && f3[2]);
`else
    return 1'b0;
`endif
  endfunction

  // First byte touched: natural alignment forced down when faults are off.
  function automatic int ref_start(input logic [2:0] f3, input logic [31:0] a);
    int nb;
    nb = nbytes(f3);
    return (int'(a) % (4*(2**AW))) & ~(nb - 1);
  endfunction

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_bytes[4*idx+3], ref_bytes[4*idx+2], ref_bytes[4*idx+1], ref_bytes[4*idx]};
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int s, nb;
    logic [31:0] v;
    s = ref_start(f3, a); nb = nbytes(f3); v = wd;
    for (int i = 0; i < nb; i++) ref_bytes[s + i] = v[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int s, nb;
    logic [31:0] v;
    s = ref_start(f3, a); nb = nbytes(f3); v = '0;
    for (int i = 0; i < nb; i++) v = v | (32'(ref_bytes[s + i]) << (8*i));
    if (nb < 4 && !f3[2] && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
    return v;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge CLK);
    while (!READY && n < 10) begin @(negedge CLK); n++; end
    if (!READY) check("ready_timeout", READY, 1'b1);
  endtask

  // One complete transaction with latency, write-pulse and result checks.
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    int n, we_cnt, lat, idx;
    bit done_seen, flt;
    wait_ready();
    WE = we; FUNCT3 = f3; ADDR = a; WDATA = wd; REQ = 1'b1;
    @(posedge CLK);
    #1 REQ = 1'b0;
    n = 0; we_cnt = 0; done_seen = 0;
    while (!done_seen && n < 8) begin
      @(negedge CLK);
      n++;
      if (MEM_WE) we_cnt++;
      if (DONE) done_seen = 1;
    end
    flt = ref_fault(we, f3, a);
    if (flt)          lat = 1;
    else if (!we)     lat = 2;
    else if (f3[1])   lat = 2;
    else              lat = 3;
    if (!flt && !we) ref_rdata = ref_load(f3, a);
    if (!flt && we)  ref_store(f3, a, wd);
    idx = int'(a[AW+1:2]);
    check("done_seen", 32'(done_seen), 32'd1);
    check("latency", 32'(n), 32'(lat));
    check("we_pulses", 32'(we_cnt), (we && !flt) ? 32'd1 : 32'd0);
    check("err", 32'(ERR), 32'(flt));
    check("rdata", RDATA, ref_rdata);
    check("mem_word", mem[idx], ref_word(idx));
  endtask

  initial begin : main
    int we_cnt;
    // Reset state.
    repeat (2) @(negedge CLK);
    check("rst_ready", 32'(READY), 32'd1);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    check("rst_mem_a", 32'(MEM_A), 32'd0);
    check("rst_mem_wd", MEM_WD, 32'd0);
    check("rst_mem_we", 32'(MEM_WE), 32'd0);
    RST_N = 1'b1;

    // Byte loads, sign and zero extension.
    do_op(1'b1, 3'b010, 32'h0000_000C, 32'h1122_3344);
    do_op(1'b0, 3'b000, 32'h0000_000F, 32'h0);
    check("lb_0f", RDATA, 32'h0000_0011);
    do_op(1'b1, 3'b000, 32'h0000_000C, 32'h0000_0080);
    do_op(1'b0, 3'b000, 32'h0000_000C, 32'h0);
    check("lb_0c", RDATA, 32'hFFFF_FF80);
    do_op(1'b0, 3'b100, 32'h0000_000C, 32'h0);
    check("lbu_0c", RDATA, 32'h0000_0080);

    // Read-modify-write byte store.
    do_op(1'b1, 3'b010, 32'h0000_000C, 32'h1122_3344);
    do_op(1'b1, 3'b000, 32'h0000_000D, 32'h0000_00AB);
    check("sb_word", mem[3], 32'h1122_AB44);
    check("sb_rdata_kept", RDATA, 32'h0000_0080);

    // Half and word.
    do_op(1'b1, 3'b001, 32'h0000_000A, 32'h0000_BEEF);
    do_op(1'b0, 3'b001, 32'h0000_000A, 32'h0);
    check("lh_0a", RDATA, 32'hFFFF_BEEF);
    do_op(1'b0, 3'b101, 32'h0000_000A, 32'h0);
    check("lhu_0a", RDATA, 32'h0000_BEEF);
    do_op(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
    do_op(1'b0, 3'b010, 32'h0000_0010, 32'h0);
    check("lw_10", RDATA, 32'hDEAD_BEEF);
    do_op(1'b0, 3'b100, 32'h0000_000D, 32'h0);   // RDATA <- 0xAB
    do_op(1'b0, 3'b010, 32'h0000_0011, 32'h0);   // misaligned word
    // Address wrap: upper bits ignored.
    do_op(1'b1, 3'b010, 32'hFFFF_FF14, 32'h0BAD_F00D);
    do_op(1'b0, 3'b010, 32'h0000_0014, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++)
      do_op(1'($urandom_range(0, 1)), 3'($urandom), $urandom, $urandom);

    // Reset during READ of an SB.
    do_op(1'b0, 3'b010, 32'h0000_000C, 32'h0);   // make RDATA reflect word 3
    wait_ready();
    WE = 1'b1; FUNCT3 = 3'b000; ADDR = 32'h0000_000D; WDATA = 32'h0000_0077; REQ = 1'b1;
    @(posedge CLK);
    #1 REQ = 1'b0;
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    ref_rdata = '0;
    check("abort_mem_we", 32'(MEM_WE), 32'd0);
    check("abort_ready", 32'(READY), 32'd1);
    check("abort_done", 32'(DONE), 32'd0);
    check("abort_rdata", RDATA, 32'd0);
    check("abort_mem_a", 32'(MEM_A), 32'd0);
    check("abort_mem_wd", MEM_WD, 32'd0);
    we_cnt = 0;
    repeat (3) begin @(negedge CLK); if (MEM_WE || DONE) we_cnt++; end
    RST_N = 1'b1;
    repeat (3) begin @(negedge CLK); if (MEM_WE || DONE) we_cnt++; end
    check("abort_no_activity", 32'(we_cnt), 32'd0);
    check("abort_ready_after", 32'(READY), 32'd1);
    check("abort_mem_word", mem[3], ref_word(3));

    // REQ held high through an SB: one execution, then a second after DONE.
    wait_ready();
    WE = 1'b1; FUNCT3 = 3'b000; ADDR = 32'h0000_000E; WDATA = 32'h0000_005A; REQ = 1'b1;
    we_cnt = 0;
    for (int n = 1; n <= 7; n++) begin
      @(negedge CLK);
      if (MEM_WE) we_cnt++;
      check($sformatf("held_done_%0d", n), 32'(DONE), (n == 3 || n == 7) ? 32'd1 : 32'd0);
      if (n == 3) begin
        check("held_we_first", 32'(we_cnt), 32'd1);
        ref_store(3'b000, 32'h0000_000E, 32'h0000_005A);
        check("held_mem_first", mem[3], ref_word(3));
        WDATA = 32'h0000_00CD;
      end
      if (n == 4) check("held_ready", 32'(READY), 32'd1);
      if (n == 5) begin
        check("held_second_accepted", 32'(READY), 32'd0);
        REQ = 1'b0;
      end
      if (n == 7) begin
        check("held_we_total", 32'(we_cnt), 32'd2);
        ref_store(3'b000, 32'h0000_000E, 32'h0000_00CD);
        check("held_mem_second", mem[3], ref_word(3));
      end
    end
    check("held_rdata_kept", RDATA, ref_rdata);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
